// File: rtl/button_step_encoder.sv
// Two-button step encoder: synchronizes and debounces up/down buttons, then emits
// one-cycle step strobes with hold-to-repeat and a both-pressed lockout.
module button_step_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic up,
    output logic down,
    output logic enable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LIMIT   = CW'(DEBOUNCE_CYCLES);
    localparam logic [27:0]   DELAY_LOAD  = 28'(REPEAT_DELAY - 1);
    localparam logic [27:0]   PERIOD_LOAD = 28'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    level;
    logic [CW-1:0] deb_cnt [2];

    state_t      state;
    state_t      next_state;
    logic [27:0] timer;
    logic [27:0] timer_next;
    logic        active;
    logic        active_next;
    logic        fire;
    logic        up_next;
    logic        down_next;
    logic        active_lvl;
    logic        other_lvl;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {btn_down_raw, btn_up_raw};
            sync2 <= sync1;
        end
    end

    // A level change is accepted once the counter has already reached the limit
    // and the sample still disagrees, so the counter never exceeds DEBOUNCE_CYCLES.
    always_ff @(posedge clk) begin
        if (reset) begin
            level      <= 2'b00;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LIMIT) begin
                    level[i]   <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign active_lvl = active ? level[1] : level[0];
    assign other_lvl  = active ? level[0] : level[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            timer  <= '0;
            active <= 1'b0;
            up     <= 1'b0;
            down   <= 1'b0;
            enable <= 1'b0;
        end else begin
            state  <= next_state;
            timer  <= timer_next;
            active <= active_next;
            up     <= up_next;
            down   <= down_next;
            enable <= up_next | down_next;
        end
    end

    // Release and lockout are tested before timer expiry so they win a tie.
    always_comb begin
        next_state  = state;
        timer_next  = timer;
        active_next = active;
        fire        = 1'b0;
        case (state)
            IDLE: begin
                if (level[0] && level[1]) begin
                    next_state = LOCK;
                end else if (level[0] || level[1]) begin
                    next_state  = DELAY;
                    active_next = level[1];
                    timer_next  = DELAY_LOAD;
                    fire        = 1'b1;
                end
            end
            DELAY, REPEAT: begin
                if (!active_lvl) begin
                    next_state = IDLE;
                end else if (other_lvl) begin
                    next_state = LOCK;
                end else if (timer == 28'd0) begin
                    next_state = REPEAT;
                    timer_next = PERIOD_LOAD;
                    fire       = 1'b1;
                end else begin
                    timer_next = timer - 28'd1;
                end
            end
            LOCK: begin
                if (!level[0] && !level[1]) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        up_next   = fire && !active_next;
        down_next = fire && active_next;
    end

endmodule

// File: tb/tb_button_step_encoder.sv
// Bench for button_step_encoder: directed scenarios feed an expected-strobe queue
// that a per-cycle monitor pops; random phase checks strobe invariants.
module tb_button_step_encoder;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 10;

    logic clk = 1'b0;
    logic reset;
    logic btn_up_raw;
    logic btn_down_raw;
    logic up;
    logic down;
    logic enable;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit seq_check = 1'b1;
    logic up_d = 1'b0;
    logic down_d = 1'b0;
    logic [33:0] exp_q[$];
    logic [33:0] exp_e;

    button_step_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up_raw  (btn_up_raw),
        .btn_down_raw(btn_down_raw),
        .up          (up),
        .down        (down),
        .enable      (enable)
    );

    // Clock and cycle numbering: after rising edge n, cyc == n.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            checks++;
            if (enable !== (up | down)) begin
                errors++;
                $display("FAIL enable_is_or cycle %0d: enable=%b up=%b down=%b", cyc, enable, up, down);
            end
            checks++;
            if ((up & down) !== 1'b0) begin
                errors++;
                $display("FAIL exclusive_strobes cycle %0d: up=%b down=%b, required not both", cyc, up, down);
            end
            checks++;
            if (((up & up_d) | (down & down_d)) !== 1'b0) begin
                errors++;
                $display("FAIL strobe_width cycle %0d: strobe high two cycles in a row", cyc);
            end
            if (seq_check && (up === 1'b1 || down === 1'b1)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe cycle %0d: up=%b down=%b, none expected", cyc, up, down);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({cyc, up, down} !== exp_e) begin
                        errors++;
                        $display("FAIL strobe_seq: got cycle %0d up=%b down=%b, expected cycle %0d up=%b down=%b",
                                 cyc, up, down, exp_e[33:2], exp_e[1], exp_e[0]);
                    end
                end
            end
            up_d   <= up;
            down_d <= down;
        end
    end

    // Driver tasks
    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Value v is sampled by the DUT at rising edge k.
    task automatic drive_at(input int k, input bit which, input logic v);
        wait_until(k - 1);
        if (which) btn_down_raw = v;
        else       btn_up_raw   = v;
    endtask

    task automatic expect_strobe(input int c, input logic u, input logic d);
        exp_q.push_back({c, u, d});
    endtask

    task automatic test_reset;
        wait_until(3);
        checks++;
        if ({up, down, enable} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: up/down/enable=%b, required 000", {up, down, enable});
        end
        reset = 1'b0;
        wait_until(15);
        checks++;
        if ({up, down, enable} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: up/down/enable=%b, required 000", {up, down, enable});
        end
    endtask

    task automatic test_single_press;
        int b;
        b = cyc + 10;
        expect_strobe(b + DEB + 3, 1'b1, 1'b0);
        drive_at(b, 1'b0, 1'b1);
        drive_at(b + 15, 1'b0, 1'b0);
        wait_until(b + 35);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_press_pending: %0d strobes missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bounce;
        int b;
        b = cyc + 10;
        expect_strobe(b + DEB + 3, 1'b0, 1'b1);
        drive_at(b - 4, 1'b1, 1'b1);
        drive_at(b - 3, 1'b1, 1'b0);
        drive_at(b - 2, 1'b1, 1'b1);
        drive_at(b - 1, 1'b1, 1'b0);
        drive_at(b, 1'b1, 1'b1);
        drive_at(b + 12, 1'b1, 1'b0);
        wait_until(b + 35);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bounce_pending: %0d strobes missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Release lands in the same cycle as the next timer expiry; release wins.
    task automatic test_auto_repeat;
        int b;
        b = cyc + 10;
        expect_strobe(b + 7, 1'b1, 1'b0);
        expect_strobe(b + 7 + RD, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) expect_strobe(b + 7 + RD + i * RP, 1'b1, 1'b0);
        drive_at(b, 1'b0, 1'b1);
        drive_at(b + 60, 1'b0, 1'b0);
        wait_until(b + 85);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL auto_repeat_pending: %0d strobes missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_lock;
        int b;
        b = cyc + 10;
        expect_strobe(b + 7, 1'b1, 1'b0);
        expect_strobe(b + 47, 1'b0, 1'b1);
        drive_at(b, 1'b0, 1'b1);
        drive_at(b + 10, 1'b1, 1'b1);
        drive_at(b + 20, 1'b0, 1'b0);
        drive_at(b + 25, 1'b1, 1'b0);
        drive_at(b + 40, 1'b1, 1'b1);
        drive_at(b + 50, 1'b1, 1'b0);
        wait_until(b + 75);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lock_pending: %0d strobes missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        int b;
        b = cyc + 10;
        expect_strobe(b + 7, 1'b1, 1'b0);
        expect_strobe(b + 15 + 2 + DEB + 3, 1'b1, 1'b0);
        drive_at(b, 1'b0, 1'b1);
        wait_until(b + 14);
        reset = 1'b1;
        for (int i = 15; i <= 17; i++) begin
            wait_until(b + i);
            if (i == 16) reset = 1'b0;
            checks++;
            if ({up, down, enable} !== 3'b000) begin
                errors++;
                $display("FAIL reset_abort cycle %0d: up/down/enable=%b, required 000", cyc, {up, down, enable});
            end
        end
        drive_at(b + 30, 1'b0, 1'b0);
        wait_until(b + 55);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_pending: %0d strobes missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Full release/repress gives a new first press; a short dip does not.
    task automatic test_back_to_back;
        int b;
        b = cyc + 10;
        expect_strobe(b + 7, 1'b1, 1'b0);
        expect_strobe(b + 27, 1'b1, 1'b0);
        expect_strobe(b + 57, 1'b1, 1'b0);
        drive_at(b, 1'b0, 1'b1);
        drive_at(b + 12, 1'b0, 1'b0);
        drive_at(b + 20, 1'b0, 1'b1);
        drive_at(b + 32, 1'b0, 1'b0);
        drive_at(b + 50, 1'b0, 1'b1);
        drive_at(b + 60, 1'b0, 1'b0);
        drive_at(b + 62, 1'b0, 1'b1);
        drive_at(b + 70, 1'b0, 1'b0);
        wait_until(b + 95);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_pending: %0d strobes missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_random;
        int stop;
        seq_check = 1'b0;
        stop = cyc + 20000;
        while (cyc < stop) begin
            btn_up_raw   = 1'($urandom_range(0, 1));
            btn_down_raw = 1'($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        wait_until(cyc + 20);
        seq_check = 1'b1;
        wait_until(cyc + 20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_quiet: %0d queued, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset        = 1'b1;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_press();
        test_bounce();
        test_auto_repeat();
        test_lock();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
